// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encoding,
// controller state encoding and the alignment/legality check.
package lsu_pkg;

    localparam int LSU_XLEN = 32;

    // Access size encoding carried on req_size
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW,
        STORE,
        RESP
    } lsu_state_e;

    // True when the access can never be serviced: illegal size, or a
    // half/word that is not naturally aligned.
    function automatic logic isAccessError(input logic [1:0] size, input logic [1:0] addrLo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addrLo[0];
            SZ_WORD: bad = (addrLo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: pulls the addressed byte/half/word out of a
// memory word and extends it, and splices store data into a memory word
// for the read-modify-write path. Lanes are little-endian.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [LSU_XLEN-1:0] rd_word_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [1:0]          size_i,
    input  logic                is_unsigned_i,
    input  logic [LSU_XLEN-1:0] wdata_i,
    output logic [LSU_XLEN-1:0] load_data_o,
    output logic [LSU_XLEN-1:0] merge_word_o
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic        byteSign;
    logic        halfSign;

    // Select the addressed lane and extend it to a full word for loads
    always_comb begin
        case (addr_lo_i)
            2'd0:    byteLane = rd_word_i[7:0];
            2'd1:    byteLane = rd_word_i[15:8];
            2'd2:    byteLane = rd_word_i[23:16];
            default: byteLane = rd_word_i[31:24];
        endcase
        halfLane = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
        byteSign = byteLane[7] & ~is_unsigned_i;
        halfSign = halfLane[15] & ~is_unsigned_i;

        load_data_o = '0;
        case (size_i)
            SZ_BYTE: load_data_o = {{24{byteSign}}, byteLane};
            SZ_HALF: load_data_o = {{16{halfSign}}, halfLane};
            SZ_WORD: load_data_o = rd_word_i;
            default: load_data_o = '0;
        endcase
    end

    // Replace only the addressed lane of the current memory word with store data
    always_comb begin
        merge_word_o = rd_word_i;
        case (size_i)
            SZ_BYTE: begin
                case (addr_lo_i)
                    2'd0:    merge_word_o[7:0]   = wdata_i[7:0];
                    2'd1:    merge_word_o[15:8]  = wdata_i[7:0];
                    2'd2:    merge_word_o[23:16] = wdata_i[7:0];
                    default: merge_word_o[31:24] = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo_i[1]) begin
                    merge_word_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_word_o[15:0] = wdata_i[15:0];
                end
            end
            SZ_WORD: merge_word_o = wdata_i;
            default: merge_word_o = rd_word_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core request at a time, talks to
// a word-addressed data memory with a combinational read port, performs
// read-modify-write for byte/half stores and returns a single response.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    lsu_state_e            state_q, state_d;
    logic                  isStore_q, isStore_d;
    logic [1:0]            size_q, size_d;
    logic                  isUnsigned_q, isUnsigned_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] writeWord_q, writeWord_d;

    logic                  reqErr;
    logic [DATA_WIDTH-1:0] wordIdx;
    logic [DATA_WIDTH-1:0] laneLoad;
    logic [DATA_WIDTH-1:0] laneMerge;

    assign reqErr  = isAccessError(req_size, req_addr[1:0]);
    assign wordIdx = {2'b00, addr_q[DATA_WIDTH-1:2]};

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    lsu_lane u_lane (
        .rd_word_i     (mem_rd),
        .addr_lo_i     (addr_q[1:0]),
        .size_i        (size_q),
        .is_unsigned_i (isUnsigned_q),
        .wdata_i       (wdata_q),
        .load_data_o   (laneLoad),
        .merge_word_o  (laneMerge)
    );

    // State and request registers; reset drops to IDLE at once so a store in
    // flight loses mem_we immediately and a pending RMW never reaches STORE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            isStore_q    <= 1'b0;
            size_q       <= 2'b00;
            isUnsigned_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            writeWord_q  <= '0;
        end else begin
            state_q      <= state_d;
            isStore_q    <= isStore_d;
            size_q       <= size_d;
            isUnsigned_q <= isUnsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            writeWord_q  <= writeWord_d;
        end
    end

    // Next-state, request capture and memory/handshake outputs per state
    always_comb begin
        state_d      = state_q;
        isStore_d    = isStore_q;
        size_d       = size_q;
        isUnsigned_d = isUnsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        writeWord_d  = writeWord_q;

        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_a      = '0;
        mem_wd     = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    isStore_d    = req_we;
                    size_d       = req_size;
                    isUnsigned_d = req_unsigned;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    err_d        = reqErr;
                    rdata_d      = '0;
                    writeWord_d  = '0;
                    if (reqErr) begin
                        state_d = RESP;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_size == SZ_WORD) begin
                        writeWord_d = req_wdata;
                        state_d     = STORE;
                    end else begin
                        state_d = RMW;
                    end
                end
            end
            LOAD: begin
                mem_a   = wordIdx;
                rdata_d = laneLoad;
                state_d = RESP;
            end
            RMW: begin
                mem_a       = wordIdx;
                writeWord_d = laneMerge;
                state_d     = STORE;
            end
            STORE: begin
                mem_a   = wordIdx;
                mem_we  = 1'b1;
                mem_wd  = writeWord_q;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: behavioural word memory, a scoreboard of
// expected responses and writes, and one task per feature.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        logic [31:0] wa;
        logic [31:0] wd;
    } exp_t;

    exp_t        expQ[$];
    logic [63:0] obsWr[$];
    logic [31:0] mem [0:255];

    lsu_ctrl #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_we       (mem_we),
        .mem_rd       (mem_rd)
    );

    always #5 clk = ~clk;

    // Word memory with combinational read and clocked write
    assign mem_rd = mem[mem_a[7:0]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:0]] <= mem_wd;
    end

    // Record every cycle the write enable is seen high
    always @(negedge clk) begin
        if (mem_we) obsWr.push_back({mem_a, mem_wd});
    end

    // Reference load extraction: shift the lane down, mask, then extend
    function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [1:0] lo,
                                            input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] v;
        sh = word >> (8 * lo);
        v  = 32'h0;
        if (size == 2'b00) begin
            v = sh & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = sh & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else if (size == 2'b10) begin
            v = word;
        end
        return v;
    endfunction

    task automatic pushExp(input logic [31:0] rdata, input logic err, input int lat,
                           input int nwr, input logic [31:0] wa, input logic [31:0] wd);
        exp_t e;
        e.rdata = rdata; e.err = err; e.lat = lat; e.nwr = nwr; e.wa = wa; e.wd = wd;
        expQ.push_back(e);
    endtask

    // Issue one request, wait for its response and compare with the scoreboard
    task automatic doReq(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        int   lat;
        exp_t e;
        @(negedge clk);
        obsWr.delete();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s ready: got %b expected 1", name, req_ready);
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        e = expQ.pop_front();
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s timeout: no response after %0d cycles", name, lat);
            return;
        end
        checks++;
        if (lat != e.lat) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
        end
        checks++;
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
            errors++;
            $display("[TB] FAIL %s resp: got rdata %h err %b expected rdata %h err %b",
                     name, resp_rdata, resp_err, e.rdata, e.err);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s ready in RESP: got %b expected 0", name, req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s return: got valid %b ready %b expected 0 1",
                     name, resp_valid, req_ready);
        end
        checks++;
        if (obsWr.size() != e.nwr) begin
            errors++;
            $display("[TB] FAIL %s write count: got %0d expected %0d", name, obsWr.size(), e.nwr);
        end else if (e.nwr == 1) begin
            checks++;
            if (obsWr[0] !== {e.wa, e.wd}) begin
                errors++;
                $display("[TB] FAIL %s write: got a %h wd %h expected a %h wd %h",
                         name, obsWr[0][63:32], obsWr[0][31:0], e.wa, e.wd);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || mem_we !== 1'b0 ||
            mem_a !== 32'h0 || resp_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset outputs: got valid %b err %b we %b a %h rdata %h expected all 0",
                     resp_valid, resp_err, mem_we, mem_a, resp_rdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_load();
        logic [31:0] w;
        w = 32'h8899AABB;
        pushExp(32'hFFFFFFAA, 1'b0, 2, 0, 0, 0);
        doReq("load_b_0x101", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
        pushExp(32'h00008899, 1'b0, 2, 0, 0, 0);
        doReq("load_hu_0x102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        for (int lo = 0; lo < 4; lo++) begin
            for (int u = 0; u < 2; u++) begin
                pushExp(refLoad(w, 2'(lo), 2'b00, u[0]), 1'b0, 2, 0, 0, 0);
                doReq("load_byte_lane", 1'b0, 2'b00, u[0], 32'h100 + 32'(lo), 32'hFFFF_FFFF);
            end
        end
        for (int u = 0; u < 2; u++) begin
            pushExp(refLoad(w, 2'd0, 2'b01, u[0]), 1'b0, 2, 0, 0, 0);
            doReq("load_half_lo", 1'b0, 2'b01, u[0], 32'h100, 32'h0);
        end
        pushExp(w, 1'b0, 2, 0, 0, 0);
        doReq("load_word", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        obsWr.delete();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b1;
        req_addr = 32'h100; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10C; req_wdata = 32'hDEAD0000;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h000000BB || resp_err !== 1'b0 ||
                req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold cycle %0d: got valid %b rdata %h err %b ready %b expected 1 000000bb 0 0",
                         i, resp_valid, resp_rdata, resp_err, req_ready);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || obsWr.size() != 0) begin
            errors++;
            $display("[TB] FAIL hold release: got valid %b ready %b writes %0d expected 0 1 0",
                     resp_valid, req_ready, obsWr.size());
        end
    endtask

    task automatic test_errors();
        pushExp(32'h0, 1'b1, 1, 0, 0, 0);
        doReq("err_load_word_0x102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
        pushExp(32'h0, 1'b1, 1, 0, 0, 0);
        doReq("err_store_size11", 1'b1, 2'b11, 1'b0, 32'h100, 32'h12345678);
        pushExp(32'h0, 1'b1, 1, 0, 0, 0);
        doReq("err_store_half_0x101", 1'b1, 2'b01, 1'b0, 32'h101, 32'h1234);
        pushExp(32'h0, 1'b1, 1, 0, 0, 0);
        doReq("err_load_half_0x103", 1'b0, 2'b01, 1'b1, 32'h103, 32'h0);
    endtask

    task automatic test_store();
        pushExp(32'h0, 1'b0, 3, 1, 32'h40, 32'h5A99AABB);
        doReq("store_b_0x103", 1'b1, 2'b00, 1'b0, 32'h103, 32'h0000005A);
        pushExp(32'h0, 1'b0, 2, 1, 32'h41, 32'h12345678);
        doReq("store_w_0x104", 1'b1, 2'b10, 1'b0, 32'h104, 32'h12345678);
        pushExp(32'h0, 1'b0, 3, 1, 32'h41, 32'hCAFE5678);
        doReq("store_h_0x106", 1'b1, 2'b01, 1'b0, 32'h106, 32'hFFFFCAFE);
    endtask

    task automatic test_reset_store();
        @(negedge clk);
        obsWr.delete();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h108; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL store state we: got %b expected 1", mem_we);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_a !== 32'h0 || resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async reset in store: got we %b a %h valid %b expected 0 0 0",
                     mem_we, mem_a, resp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem[8'h42] !== 32'h11223344 ||
            obsWr.size() != 0) begin
            errors++;
            $display("[TB] FAIL after store reset: got ready %b valid %b mem %h writes %0d expected 1 0 11223344 0",
                     req_ready, resp_valid, mem[8'h42], obsWr.size());
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h109; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (obsWr.size() != 0 || mem[8'h42] !== 32'h11223344 || resp_valid !== 1'b0 ||
            req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after rmw reset: got writes %0d mem %h valid %b ready %b expected 0 11223344 0 1",
                     obsWr.size(), mem[8'h42], resp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        pushExp(32'h0000005A, 1'b0, 2, 0, 0, 0);
        doReq("reload_bu_0x103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
        pushExp(32'hCAFE5678, 1'b0, 2, 0, 0, 0);
        doReq("reload_w_0x104", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
        pushExp(32'hFFFFCAFE, 1'b0, 2, 0, 0, 0);
        doReq("reload_h_0x106", 1'b0, 2'b01, 1'b0, 32'h106, 32'h0);
        pushExp(32'h00005678, 1'b0, 2, 0, 0, 0);
        doReq("reload_hu_0x104", 1'b0, 2'b01, 1'b1, 32'h104, 32'h0);
    endtask

    // Main sequence
    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[8'h40] <= 32'h8899AABB;
        mem[8'h42] <= 32'h11223344;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        test_reset();
        test_load();
        test_backpressure();
        test_errors();
        test_store();
        test_reset_store();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter DATA_WIDTH SHALL default 32 and set the data and address width; the only supported value is 32.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1, reset, asynchronous and active-high.
REQ-004 Port req_valid, input, 1: core request present.
REQ-005 Port req_ready, output, 1: block accepts a request this cycle.
REQ-006 Port req_we, input, 1: 1 = store, 0 = load.
REQ-007 Port req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 Port req_unsigned, input, 1: zero-extend loads when 1, sign-extend when 0.
REQ-009 Port req_addr, input, DATA_WIDTH: byte address.
REQ-010 Port req_wdata, input, DATA_WIDTH: store data, right-aligned.
REQ-011 Port resp_valid, output, 1: response present.
REQ-012 Port resp_ready, input, 1: core takes the response.
REQ-013 Port resp_rdata, output, DATA_WIDTH: extended load data; 0 for stores and errors.
REQ-014 Port resp_err, output, 1: misaligned access or illegal size.
REQ-015 Port mem_a, output, DATA_WIDTH: word index to data memory, {2'b00, addr[31:2]}.
REQ-016 Port mem_wd, output, DATA_WIDTH: write word to data memory.
REQ-017 Port mem_we, output, 1: data memory write enable.
REQ-018 Port mem_rd, input, DATA_WIDTH: combinational read word from data memory at mem_a.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, RMW, STORE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted when req_valid and req_ready are both 1; all req_* fields SHALL be latched on acceptance.
REQ-021 Error condition: size 11, half with addr[0]=1, or word with addr[1:0]!=0.
REQ-022 On an error, IDLE SHALL go to RESP with resp_err=1, and memory SHALL NOT be accessed.
REQ-023 On a load, IDLE SHALL go to LOAD.
REQ-024 In LOAD, mem_a is driven, the lane selected by addr[1:0] is extracted from mem_rd and extended, the result is registered, and the FSM goes to RESP.
REQ-025 On a word store, IDLE SHALL go to STORE.
REQ-026 On a byte or half store, IDLE SHALL go to RMW.
REQ-027 In RMW, the block reads mem_rd, replaces only the addressed byte or half lane with req_wdata low bits, registers the merged word, and goes to STORE.
REQ-028 In STORE, mem_we=1 and mem_wd=write word for exactly one cycle, then the FSM goes to RESP.
REQ-029 mem_we SHALL be 0 in every state except STORE.
REQ-030 In RESP, resp_valid=1 and response fields SHALL hold stable until resp_ready=1, then the FSM returns to IDLE.
REQ-031 A new request SHALL NOT be accepted in the cycle a response is taken.
REQ-032 Latency from acceptance edge to resp_valid: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-033 mem_a SHALL hold the latched word index in LOAD, RMW and STORE, and 0 otherwise.
REQ-034 Little-endian lanes: byte n is bits [8n+7:8n], half at addr[1]=1 is bits [31:16].

Reset
REQ-035 On rst, the FSM SHALL enter IDLE immediately.
REQ-036 On rst, resp_valid, resp_err, mem_we and mem_a SHALL be 0, and resp_rdata and all latched registers SHALL be 0.
REQ-037 rst asserted during STORE SHALL force mem_we low asynchronously; a partially completed RMW SHALL NOT write.
REQ-038 After rst deasserts, req_ready SHALL be 1 in the first cycle.

Structure
REQ-039 Package lsu_pkg SHALL hold the size encoding (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-040 A combinational sub-module lsu_lane SHALL perform lane extract/extend and lane merge; the FSM and registers stay in lsu_ctrl.

Verification
REQ-041 Memory word 0x00000040 = 0x8899AABB, load byte signed at 0x101 -> resp_rdata 0xFFFFFFAA, resp_err 0, resp_valid 2 cycles after accept.
REQ-042 Same word, load half unsigned at 0x102 -> resp_rdata 0x00008899.
REQ-043 Store byte 0x5A at 0x103 -> exactly one mem_we pulse with mem_wd 0x5A99AABB, response 3 cycles after accept.
REQ-044 Store word 0x12345678 at 0x104 -> mem_a 0x41, mem_wd 0x12345678, response 2 cycles after accept.
REQ-045 Load word at 0x102, and separately size 11 -> resp_err 1 after 1 cycle, mem_we never 1.
REQ-046 resp_ready held 0 for 5 cycles -> response stable and req_ready 0 throughout; rst pulsed during STORE -> no write and IDLE.
